// File: rtl/ualink_pkt_gen_if.sv
// Multi-port AXI-Stream bundle driven by the UALink request generator.
interface ualink_pkt_gen_if #(
  parameter int NUM_PORTS = 5,
  parameter int DW        = 64,
  parameter int TUW       = 128
) ();
  logic [NUM_PORTS-1:0][DW-1:0]   tdata;
  logic [NUM_PORTS-1:0][DW/8-1:0] tstrb;
  logic [NUM_PORTS-1:0][TUW-1:0]  tuser;
  logic [NUM_PORTS-1:0]           tvalid;
  logic [NUM_PORTS-1:0]           tready;
  logic [NUM_PORTS-1:0]           tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ualink_pkt_gen.sv
// UALink-over-UDP read/write request generator driving NUM_PORTS AXI-Stream masters.
// Define PKTGEN_RANDOM_PORT_EN to pick each packet's port from an 8-bit LFSR instead of port_sel.
module ualink_pkt_gen_lane #(
  parameter int DW  = 64,
  parameter int TUW = 128
) (
  input  logic            sel,
  input  logic            vld,
  input  logic            last,
  input  logic [DW-1:0]   data,
  output logic [DW-1:0]   tdata,
  output logic [DW/8-1:0] tstrb,
  output logic [TUW-1:0]  tuser,
  output logic            tvalid,
  output logic            tlast
);
  assign tvalid = sel & vld;
  assign tlast  = sel & vld & last;
  assign tdata  = sel ? data : '0;
  assign tstrb  = sel ? '1 : '0;
  assign tuser  = sel ? TUW'(8'hAA) : '0;
endmodule

module ualink_pkt_gen #(
  parameter int NUM_PORTS            = 5,
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int WR_LEN_WORDS         = 32,
  parameter int RD_LEN_WORDS         = 24,
  parameter int GAP_CYCLES           = 8,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic          axi_aclk,
  input  logic          axi_resetn,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] port_sel,
  input  logic [15:0]   pkt_count,
  input  logic [15:0]   addr_base,
  input  logic [7:0]    data_byte,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pkts_sent,
  ualink_pkt_gen_if.master m_axis
);
  localparam int DW  = C_M_AXIS_DATA_WIDTH;
  localparam int TUW = C_M_AXIS_TUSER_WIDTH;
  localparam logic [15:0] WR_LAST  = 16'(WR_LEN_WORDS - 1);
  localparam logic [15:0] RD_LAST  = 16'(RD_LEN_WORDS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_GAP, S_FIN} state_t;

  state_t        state;
  logic [1:0]    mode_r;
  logic [PW-1:0] port_r;
  logic [15:0]   cnt_r, addr_r, idx, gap_cnt;
  logic [7:0]    byte_r;
  logic          op_wr, stop_seen, tvalid_r, tlast_r;
  logic [63:0]   tdata_r;
  logic          hs, run_over;
  logic [15:0]   nidx, last_idx;

  function automatic logic [63:0] beat_word(input logic [15:0] i, input logic wr,
                                            input logic [15:0] a, input logic [7:0] b);
    logic [63:0] w;
    case (i)
      16'd0:   w = 64'h0000FFFFFFFFFFFF;
      16'd1:   w = {(wr ? 8'h02 : 8'h01), 56'h45000800000000};
      16'd2:   w = 64'h1140000001000600;
      16'd3:   w = 64'hA8C000000000DCB9;
      16'd4:   w = 64'h4C00393035000600;
      16'd5:   w = {48'h5A3030303030, a};
      default: w = (wr && i <= 16'd13) ? {8{b}} : {8{i[7:0]}};
    endcase
    return w;
  endfunction

  assign hs       = tvalid_r & m_axis.tready[port_r];
  assign nidx     = idx + 16'd1;
  assign last_idx = op_wr ? WR_LAST : RD_LAST;
  // stop may arrive on the very cycle the gap expires; it still ends the run
  assign run_over = ((cnt_r != 16'd0) && (pkts_sent == cnt_r)) || stop_seen || stop;

`ifdef PKTGEN_RANDOM_PORT_EN
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nxt;
  logic [PW-1:0] rnd_port;
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign rnd_port = PW'(lfsr % 8'(NUM_PORTS));
`endif

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state     <= S_IDLE;
      mode_r    <= '0;
      port_r    <= '0;
      cnt_r     <= '0;
      addr_r    <= '0;
      byte_r    <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      op_wr     <= 1'b1;
      stop_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= '0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= '0;
`ifdef PKTGEN_RANDOM_PORT_EN
      lfsr      <= 8'h01;
`endif
    end else begin
      done <= 1'b0;
      if (busy && stop) stop_seen <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          mode_r    <= mode;
          cnt_r     <= pkt_count;
          addr_r    <= addr_base;
          byte_r    <= data_byte;
          op_wr     <= ~mode[0];
          stop_seen <= stop;
          pkts_sent <= '0;
          busy      <= 1'b1;
`ifdef PKTGEN_RANDOM_PORT_EN
          port_r    <= rnd_port;
          lfsr      <= lfsr_nxt;
`else
          port_r    <= port_sel;
`endif
          idx       <= '0;
          tvalid_r  <= 1'b1;
          tlast_r   <= 1'b0;
          tdata_r   <= beat_word(16'd0, 1'b1, 16'd0, 8'd0);
          state     <= S_PKT;
        end
        S_PKT: if (hs) begin
          if (tlast_r) begin
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            tdata_r   <= '0;
            pkts_sent <= pkts_sent + 16'd1;
            addr_r    <= addr_r + 16'd1;
            if (mode_r == 2'b10) op_wr <= ~op_wr;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end else begin
            idx     <= nidx;
            tdata_r <= beat_word(nidx, op_wr, addr_r, byte_r);
            tlast_r <= (nidx == last_idx);
          end
        end
        S_GAP: if (gap_cnt == GAP_LAST) begin
          if (run_over) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
`ifdef PKTGEN_RANDOM_PORT_EN
            port_r <= rnd_port;
            lfsr   <= lfsr_nxt;
`endif
            idx      <= '0;
            tvalid_r <= 1'b1;
            tlast_r  <= 1'b0;
            tdata_r  <= beat_word(16'd0, op_wr, addr_r, byte_r);
            state    <= S_PKT;
          end
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // upper lanes of wide buses carry the fill byte; the protocol word sits in [63:0]
  logic [DW-1:0] beat_data;
  always_comb begin
    beat_data = '0;
    if (tvalid_r) begin
      beat_data       = {(DW/8){byte_r}};
      beat_data[63:0] = tdata_r;
    end
  end

  logic [NUM_PORTS-1:0][DW-1:0]   lane_tdata;
  logic [NUM_PORTS-1:0][DW/8-1:0] lane_tstrb;
  logic [NUM_PORTS-1:0][TUW-1:0]  lane_tuser;
  logic [NUM_PORTS-1:0]           lane_tvalid, lane_tlast;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    ualink_pkt_gen_lane #(.DW(DW), .TUW(TUW)) u_lane (
      .sel    (busy && (port_r == PW'(p))),
      .vld    (tvalid_r),
      .last   (tlast_r),
      .data   (beat_data),
      .tdata  (lane_tdata[p]),
      .tstrb  (lane_tstrb[p]),
      .tuser  (lane_tuser[p]),
      .tvalid (lane_tvalid[p]),
      .tlast  (lane_tlast[p])
    );
  end

  assign m_axis.tdata  = lane_tdata;
  assign m_axis.tstrb  = lane_tstrb;
  assign m_axis.tuser  = lane_tuser;
  assign m_axis.tvalid = lane_tvalid;
  assign m_axis.tlast  = lane_tlast;
endmodule
